// File: rtl/lifo_drain.sv
// Read-side controller for an external LIFO stack: tracks occupancy from the producer's
// pushes and, on command, pops the stack empty onto a valid/ready stream, flagging the last word.
module lifo_drain #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_seen,
    input  logic                    drain_start,
    input  logic                    err_clr,
    output logic                    stk_read_e,
    input  logic [WIDTH-1:0]        stk_dout,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [WIDTH-1:0]        m_data,
    output logic                    m_last,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    err
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] LEVEL_MAX = LW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, POP, CAPT, HOLD} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              handshake;
    logic              err_set;
    logic              stk_read_e_nxt;
    logic              m_valid_nxt;
    logic [WIDTH-1:0]  m_data_nxt;
    logic              m_last_nxt;
    logic              busy_nxt;
    logic [LW-1:0]     level_nxt;
    logic              err_nxt;

    assign handshake = m_valid && m_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // NOTE: every signal written in a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (drain_start && level != '0) state_nxt = POP;
            POP:     state_nxt = CAPT;
            CAPT:    state_nxt = HOLD;
            HOLD:    if (handshake) state_nxt = (level != '0) ? POP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stk_read_e_nxt = (state_nxt == POP);
        // busy also covers the cycle after the final handshake, so it falls one cycle later
        busy_nxt       = (state != IDLE) || (state_nxt != IDLE);
        m_valid_nxt    = m_valid;
        m_data_nxt     = m_data;
        m_last_nxt     = m_last;
        level_nxt      = level;
        err_set        = push_seen && ((state != IDLE) || (level == LEVEL_MAX));

        if (state == CAPT) begin
            m_valid_nxt = 1'b1;
            m_data_nxt  = stk_dout;
            m_last_nxt  = (level == '0);
        end else if (state == HOLD && handshake) begin
            m_valid_nxt = 1'b0;
        end

        if (state == POP)
            level_nxt = level - LW'(1);
        else if (state == IDLE && push_seen && level != LEVEL_MAX)
            level_nxt = level + LW'(1);

        if (err_set)      err_nxt = 1'b1;
        else if (err_clr) err_nxt = 1'b0;
        else              err_nxt = err;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stk_read_e <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_last     <= 1'b0;
            busy       <= 1'b0;
            level      <= '0;
            err        <= 1'b0;
        end else begin
            stk_read_e <= stk_read_e_nxt;
            m_valid    <= m_valid_nxt;
            m_data     <= m_data_nxt;
            m_last     <= m_last_nxt;
            busy       <= busy_nxt;
            level      <= level_nxt;
            err        <= err_nxt;
        end
    end

endmodule

// File: tb/tb_lifo_drain.sv
// Self-checking bench for lifo_drain: a queue-based stack stands in for the LIFO and a
// queue of pushed words predicts the popped sequence.
module tb_lifo_drain;
    localparam int WIDTH = 11;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              push_seen = 1'b0;
    logic              drain_start = 1'b0;
    logic              err_clr = 1'b0;
    logic              stk_read_e;
    logic [WIDTH-1:0]  stk_dout;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [WIDTH-1:0]  m_data;
    logic              m_last;
    logic              busy;
    logic [LW-1:0]     level;
    logic              err;

    logic [WIDTH-1:0]  wdata = '0;
    logic [WIDTH-1:0]  stk_q[$];
    logic [WIDTH-1:0]  model_q[$];
    int                total = 0;
    int                bad = 0;

    lifo_drain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .push_seen(push_seen), .drain_start(drain_start),
        .err_clr(err_clr), .stk_read_e(stk_read_e), .stk_dout(stk_dout),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .level(level), .err(err)
    );

    always #5 clk = ~clk;

    // Stack stand-in: word appears on stk_dout the cycle after a sampled read enable.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            stk_q.delete();
            stk_dout <= '0;
        end else begin
            if (stk_read_e) begin
                if (stk_q.size() > 0) stk_dout <= stk_q.pop_back();
                else                  stk_dout <= 'x;
            end
            if (push_seen && stk_q.size() < DEPTH - 1) stk_q.push_back(wdata);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [WIDTH-1:0] d);
        push_seen = 1'b1;
        wdata     = d;
        step();
        push_seen = 1'b0;
        if (model_q.size() < DEPTH - 1) model_q.push_back(d);
    endtask

    // mode 0: m_ready always high; 1: random m_ready plus stray drain_start; 2: 10-cycle stall on first word
    task automatic run_drain(input int mode, input string tag);
        logic [WIDTH-1:0] exp_q[$];
        logic [WIDTH-1:0] got_d[$];
        logic             got_l[$];
        int               pulses[$];
        int               n, first_valid, busy_cycles, stall_left;
        logic             hold_pending;
        logic [WIDTH-1:0] hold_data;
        logic             hold_last;
        exp_q        = model_q;
        n            = exp_q.size();
        first_valid  = -1;
        busy_cycles  = 0;
        stall_left   = 10;
        hold_pending = 1'b0;
        hold_data    = '0;
        hold_last    = 1'b0;
        drain_start  = 1'b1;
        step();
        drain_start  = 1'b0;
        for (int c = 1; c <= 600; c++) begin
            case (mode)
                0: m_ready = 1'b1;
                1: begin
                    m_ready     = ($urandom_range(0, 99) < 60);
                    drain_start = ($urandom_range(0, 9) == 0);
                end
                default: begin
                    if (m_valid && stall_left > 0) begin
                        m_ready = 1'b0;
                        stall_left--;
                    end else begin
                        m_ready = 1'b1;
                    end
                end
            endcase
            if (m_valid && first_valid < 0) first_valid = c;
            if (busy) busy_cycles++;
            if (stk_read_e) pulses.push_back(c);
            if (hold_pending) begin
                check({tag, "_stall_valid"}, m_valid, 1);
                check({tag, "_stall_data"}, m_data, hold_data);
                check({tag, "_stall_last"}, m_last, hold_last);
                check({tag, "_stall_rd"}, stk_read_e, 0);
            end
            hold_pending = m_valid && !m_ready;
            hold_data    = m_data;
            hold_last    = m_last;
            if (m_valid && m_ready) begin
                got_d.push_back(m_data);
                got_l.push_back(m_last);
            end
            if (got_d.size() == n && !busy) break;
            step();
        end
        drain_start = 1'b0;
        check({tag, "_count"}, got_d.size(), n);
        for (int i = 0; i < got_d.size() && i < n; i++) begin
            check($sformatf("%s_data%0d", tag, i), got_d[i], exp_q[n-1-i]);
            check($sformatf("%s_last%0d", tag, i), got_l[i], 32'(i == n - 1));
        end
        check({tag, "_pulses"}, pulses.size(), n);
        for (int i = 1; i < pulses.size(); i++) begin
            check($sformatf("%s_gap%0d", tag, i), 32'(pulses[i] - pulses[i-1] >= 2), 1);
            if (mode == 0) check($sformatf("%s_pitch%0d", tag, i), pulses[i] - pulses[i-1], 3);
        end
        if (mode == 0) begin
            check({tag, "_first_rd"}, (pulses.size() > 0) ? pulses[0] : -1, 1);
            check({tag, "_first_valid"}, first_valid, 3);
            check({tag, "_busy_cycles"}, busy_cycles, 3 * n + 1);
        end
        if (mode == 2) check({tag, "_first_valid"}, first_valid, 3);
        check({tag, "_level_end"}, level, 0);
        check({tag, "_busy_end"}, busy, 0);
        model_q.delete();
    endtask

    initial begin
        logic [WIDTH-1:0] r;
        int               n;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        step();

        check("rst_rd", stk_read_e, 0);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_last", m_last, 0);
        check("rst_busy", busy, 0);
        check("rst_level", level, 0);
        check("rst_err", err, 0);

        do_push(11'h101);
        do_push(11'h202);
        do_push(11'h303);
        check("basic_level", level, 3);
        run_drain(0, "basic");

        do_push(11'h101);
        do_push(11'h202);
        do_push(11'h303);
        run_drain(2, "bp");

        drain_start = 1'b1;
        step();
        drain_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("empty_rd%0d", i), stk_read_e, 0);
            check($sformatf("empty_busy%0d", i), busy, 0);
            step();
        end
        check("empty_err", err, 0);

        for (int i = 0; i < DEPTH - 1; i++) do_push(11'($urandom));
        check("full_level", level, DEPTH - 1);
        check("full_err_before", err, 0);
        do_push(11'($urandom));
        check("ovf_level", level, DEPTH - 1);
        check("ovf_err", err, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("ovf_err_clr", err, 0);
        run_drain(1, "full");

        do_push(11'h7FF);
        run_drain(0, "single");

        r = 11'($urandom);
        do_push(r);
        m_ready     = 1'b0;
        drain_start = 1'b1;
        step();
        drain_start = 1'b0;
        check("proto_pop_rd", stk_read_e, 1);
        push_seen = 1'b1;
        wdata     = 11'($urandom);
        step();
        push_seen = 1'b0;
        check("proto_pop_err", err, 1);
        check("proto_pop_level", level, 0);
        step();
        check("proto_hold_valid", m_valid, 1);
        err_clr   = 1'b1;
        push_seen = 1'b1;
        step();
        err_clr   = 1'b0;
        push_seen = 1'b0;
        check("proto_hold_err", err, 1);
        check("proto_hold_level", level, 0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("proto_clr_err", err, 0);
        check("proto_data", m_data, r);
        check("proto_last", m_last, 1);
        m_ready = 1'b1;
        step();
        check("proto_valid_drop", m_valid, 0);
        repeat (2) step();
        check("proto_busy_end", busy, 0);
        rst = 1'b0;
        #2 rst = 1'b1;
        model_q.delete();
        step();

        do_push(11'($urandom));
        do_push(11'($urandom));
        m_ready     = 1'b0;
        drain_start = 1'b1;
        step();
        drain_start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (m_valid) break;
            step();
        end
        check("mid_hold_valid", m_valid, 1);
        #2 rst = 1'b0;
        #1;
        check("async_valid", m_valid, 0);
        check("async_busy", busy, 0);
        check("async_level", level, 0);
        check("async_rd", stk_read_e, 0);
        check("async_data", m_data, 0);
        check("async_last", m_last, 0);
        step();
        rst = 1'b1;
        model_q.delete();
        step();
        check("post_rst_busy", busy, 0);
        check("post_rst_rd", stk_read_e, 0);
        do_push(11'($urandom));
        run_drain(0, "post_rst");

        for (int rnd = 0; rnd < 8; rnd++) begin
            n = $urandom_range(1, DEPTH - 1);
            for (int i = 0; i < n; i++) do_push(11'($urandom));
            check($sformatf("rnd%0d_level", rnd), level, n);
            run_drain(1, $sformatf("rnd%0d", rnd));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
